// File: rtl/ahb_lite_slave_mux_if.sv
// ----------------------------------------------------------------------------
// ahb_lite_slave_mux_if
//   Bus bundle around the AHB-Lite data-phase response multiplexer.
//   Address-phase request signals come from the master and the decoder.
//   Data-phase response signals come from slot 1 (memory) and slot 2 (AES128).
//   The muxed HRDATA/HREADY/HRESP go back to the master and all slaves.
//
//   modport slave  : view used by the multiplexer.
//                    Request and slave responses are inputs.
//                    HRDATA/HREADY/HRESP are outputs.
//   modport master : view used by the surrounding system or a bench, which
//                    drives the request and slave responses and observes the
//                    muxed response.
// ----------------------------------------------------------------------------
interface ahb_lite_slave_mux_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    // address phase (decoder / master)
    logic                  HSELx1;
    logic                  HSELx2;
    logic [1:0]            HTRANS;
    logic [ADDR_WIDTH-1:0] HADDR;
    // data phase, slot 1 (memory)
    logic [DATA_WIDTH-1:0] HRDATAx1;
    logic                  HREADYOUTx1;
    logic                  HRESPx1;
    // data phase, slot 2 (AES128)
    logic [DATA_WIDTH-1:0] HRDATAx2;
    logic                  HREADYOUTx2;
    logic                  HRESPx2;
    // muxed response to master
    logic [DATA_WIDTH-1:0] HRDATA;
    logic                  HREADY;
    logic                  HRESP;

    modport slave (
        input  HSELx1, HSELx2, HTRANS, HADDR,
        input  HRDATAx1, HREADYOUTx1, HRESPx1,
        input  HRDATAx2, HREADYOUTx2, HRESPx2,
        output HRDATA, HREADY, HRESP
    );

    modport master (
        output HSELx1, HSELx2, HTRANS, HADDR,
        output HRDATAx1, HREADYOUTx1, HRESPx1,
        output HRDATAx2, HREADYOUTx2, HRESPx2,
        input  HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb_lite_slave_mux.sv
// ----------------------------------------------------------------------------
// ahb_lite_slave_mux
//   AHB-Lite data-phase response multiplexer with a built-in default slave.
//
//   Behaviour
//     - Registers the decoder selects on every edge where HREADY=1.
//       Slot 1 (memory) wins over slot 2 (AES128).
//     - Routes the owning slave's response back to the master.
//     - An active transfer (NONSEQ/SEQ) to an unmapped address gets the
//       two-cycle ERROR response from the internal default slave.
//
//   Ports
//     HCLK      in   bus clock, rising edge
//     HRESET    in   asynchronous active-high reset
//     bus       ahb_lite_slave_mux_if.slave
//               (HSELx1/2, HTRANS, HADDR, HRDATAx1/2, HREADYOUTx1/2,
//                HRESPx1/2 in; HRDATA, HREADY, HRESP out)
//     ERR_ADDR  out  HADDR of the last unmapped access   (AHB_MUX_ERR_CAPTURE_EN)
//     ERR_VALID out  sticky flag, an unmapped access seen (AHB_MUX_ERR_CAPTURE_EN)
//
//   Optional feature macro: AHB_MUX_ERR_CAPTURE_EN
// ----------------------------------------------------------------------------
module ahb_lite_slave_mux #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    ahb_lite_slave_mux_if.slave   bus
`ifdef AHB_MUX_ERR_CAPTURE_EN
    ,
    output logic [ADDR_WIDTH-1:0] ERR_ADDR,
    output logic                  ERR_VALID
`endif
);

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_e;

    localparam logic [1:0] SEL_DEF = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_AES = 2'b10;

    logic [1:0]            sel_q, sel_d;
    ds_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] hrdata_mux;
    logic                  hready_mux;
    logic                  hresp_mux;
    logic                  unmapped_req;

    // An active transfer that no slave claims.
    assign unmapped_req = ~bus.HSELx1 & ~bus.HSELx2 & bus.HTRANS[1];

    // Response mux. sel_q=11 cannot occur and falls back to the default slave.
    always_comb begin
        hrdata_mux = '0;
        hready_mux = 1'b1;
        hresp_mux  = 1'b0;
        case (sel_q)
            SEL_MEM: begin
                hrdata_mux = bus.HRDATAx1;
                hready_mux = bus.HREADYOUTx1;
                hresp_mux  = bus.HRESPx1;
            end
            SEL_AES: begin
                hrdata_mux = bus.HRDATAx2;
                hready_mux = bus.HREADYOUTx2;
                hresp_mux  = bus.HRESPx2;
            end
            default: begin
                case (state_q)
                    DS_ERR1: begin
                        hready_mux = 1'b0;
                        hresp_mux  = 1'b1;
                    end
                    DS_ERR2: begin
                        hready_mux = 1'b1;
                        hresp_mux  = 1'b1;
                    end
                    default: begin
                        hready_mux = 1'b1;
                        hresp_mux  = 1'b0;
                    end
                endcase
            end
        endcase
    end

    assign bus.HRDATA = hrdata_mux;
    assign bus.HREADY = hready_mux;
    assign bus.HRESP  = hresp_mux;

    // Owner and default-slave next state; both advance only when HREADY=1.
    always_comb begin
        sel_d   = sel_q;
        state_d = state_q;
        if (hready_mux) begin
            sel_d = {bus.HSELx2 & ~bus.HSELx1, bus.HSELx1};
        end
        case (state_q)
            DS_IDLE: if (hready_mux && unmapped_req) state_d = DS_ERR1;
            DS_ERR1: state_d = DS_ERR2;
            DS_ERR2: state_d = unmapped_req ? DS_ERR1 : DS_IDLE;
            default: state_d = DS_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            sel_q   <= SEL_DEF;
            state_q <= DS_IDLE;
        end else begin
            sel_q   <= sel_d;
            state_q <= state_d;
        end
    end

`ifdef AHB_MUX_ERR_CAPTURE_EN
    logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
    logic                  err_valid_q, err_valid_d;

    // DS_ERR1 is never held, so state_d==DS_ERR1 marks exactly the entry edge.
    always_comb begin
        err_addr_d  = err_addr_q;
        err_valid_d = err_valid_q;
        if (state_d == DS_ERR1) begin
            err_addr_d  = bus.HADDR;
            err_valid_d = 1'b1;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            err_addr_q  <= '0;
            err_valid_q <= 1'b0;
        end else begin
            err_addr_q  <= err_addr_d;
            err_valid_q <= err_valid_d;
        end
    end

    assign ERR_ADDR  = err_addr_q;
    assign ERR_VALID = err_valid_q;
`else
    logic unused_haddr;
    assign unused_haddr = ^bus.HADDR;
`endif

endmodule

// File: tb/tb_ahb_lite_slave_mux.sv
// ----------------------------------------------------------------------------
// tb_ahb_lite_slave_mux
//   Directed bench for ahb_lite_slave_mux.
//   Inputs change 1 time unit after the rising edge.
//   Outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_ahb_lite_slave_mux;

    logic HCLK;
    logic HRESET;
    int   checks;
    int   errors;

    ahb_lite_slave_mux_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

`ifdef AHB_MUX_ERR_CAPTURE_EN
    logic [31:0] err_addr;
    logic        err_valid;
`endif

    ahb_lite_slave_mux #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
`ifdef AHB_MUX_ERR_CAPTURE_EN
        ,
        .ERR_ADDR  (err_addr),
        .ERR_VALID (err_valid)
`endif
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic next_cycle();
        @(posedge HCLK);
        #1;
    endtask

    task automatic expect_resp(input string tag, input logic rdy, input logic rsp,
                               input logic [31:0] data);
        @(negedge HCLK);
        check({tag, ".hready"}, {31'd0, bus.HREADY}, {31'd0, rdy});
        check({tag, ".hresp"},  {31'd0, bus.HRESP},  {31'd0, rsp});
        check({tag, ".hrdata"}, bus.HRDATA, data);
    endtask

    task automatic idle_bus();
        bus.HSELx1 = 1'b0;
        bus.HSELx2 = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HADDR  = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        HRESET = 1'b1;
        idle_bus();
        bus.HRDATAx1 = '0; bus.HREADYOUTx1 = 1'b1; bus.HRESPx1 = 1'b0;
        bus.HRDATAx2 = '0; bus.HREADYOUTx2 = 1'b1; bus.HRESPx2 = 1'b0;

        // reset state
        expect_resp("reset", 1'b1, 1'b0, 32'h0);
        next_cycle();
        HRESET = 1'b0;
        next_cycle();

        // memory read with two wait states
        bus.HSELx1 = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = 32'h0000_0100;
        expect_resp("mem.addr", 1'b1, 1'b0, 32'h0);
        next_cycle();
        idle_bus();
        bus.HRDATAx1 = 32'hDEAD_BEEF; bus.HREADYOUTx1 = 1'b0;
        expect_resp("mem.wait1", 1'b0, 1'b0, 32'hDEAD_BEEF);
        next_cycle();
        expect_resp("mem.wait2", 1'b0, 1'b0, 32'hDEAD_BEEF);
        next_cycle();
        bus.HREADYOUTx1 = 1'b1;
        expect_resp("mem.done", 1'b1, 1'b0, 32'hDEAD_BEEF);
        next_cycle();
        expect_resp("mem.after", 1'b1, 1'b0, 32'h0);

        // back-to-back memory then AES, no bubble
        next_cycle();
        bus.HSELx1 = 1'b1; bus.HTRANS = 2'b10;
        next_cycle();
        bus.HSELx1 = 1'b0; bus.HSELx2 = 1'b1; bus.HTRANS = 2'b10;
        bus.HRDATAx1 = 32'hA5A5_0001;
        bus.HRDATAx2 = 32'h1234_5678; bus.HREADYOUTx2 = 1'b1; bus.HRESPx2 = 1'b0;
        expect_resp("b2b.mem", 1'b1, 1'b0, 32'hA5A5_0001);
        next_cycle();
        idle_bus();
        expect_resp("b2b.aes", 1'b1, 1'b0, 32'h1234_5678);
        next_cycle();
        expect_resp("b2b.idle", 1'b1, 1'b0, 32'h0);

        // both selects asserted: memory owns the data phase
        bus.HSELx1 = 1'b1; bus.HSELx2 = 1'b1; bus.HTRANS = 2'b10;
        bus.HRDATAx1 = 32'h1111_1111; bus.HRDATAx2 = 32'h2222_2222;
        next_cycle();
        idle_bus();
        expect_resp("both.mem_wins", 1'b1, 1'b0, 32'h1111_1111);
        next_cycle();

        // unmapped NONSEQ gets a two-cycle ERROR
        bus.HTRANS = 2'b10; bus.HADDR = 32'h8000_0000;
        expect_resp("unm.addr", 1'b1, 1'b0, 32'h0);
        next_cycle();
        idle_bus();
        expect_resp("unm.err1", 1'b0, 1'b1, 32'h0);
        next_cycle();
        expect_resp("unm.err2", 1'b1, 1'b1, 32'h0);
`ifdef AHB_MUX_ERR_CAPTURE_EN
        check("cap.addr", err_addr, 32'h8000_0000);
        check("cap.valid", {31'd0, err_valid}, 32'd1);
`endif
        // a fresh unmapped SEQ during ERR2 chains straight into ERR1
        bus.HTRANS = 2'b11; bus.HADDR = 32'h9000_0004;
        next_cycle();
        idle_bus();
        expect_resp("chain.err1", 1'b0, 1'b1, 32'h0);
        next_cycle();
        expect_resp("chain.err2", 1'b1, 1'b1, 32'h0);
        next_cycle();
        expect_resp("chain.idle", 1'b1, 1'b0, 32'h0);
`ifdef AHB_MUX_ERR_CAPTURE_EN
        check("cap.addr2", err_addr, 32'h9000_0004);
        check("cap.sticky", {31'd0, err_valid}, 32'd1);
`endif

        // unmapped IDLE/BUSY: zero-wait OKAY every cycle
        for (int i = 0; i < 4; i++) begin
            bus.HTRANS = (i % 2 == 0) ? 2'b00 : 2'b01;
            bus.HADDR  = 32'hF000_0000 + 32'(i);
            next_cycle();
            expect_resp("unm.idle", 1'b1, 1'b0, 32'h0);
        end
        idle_bus();

        // AES two-cycle ERROR passes through unchanged
        next_cycle();
        bus.HSELx2 = 1'b1; bus.HTRANS = 2'b10;
        next_cycle();
        idle_bus();
        bus.HRDATAx2 = 32'h0; bus.HREADYOUTx2 = 1'b0; bus.HRESPx2 = 1'b1;
        expect_resp("aeserr.c1", 1'b0, 1'b1, 32'h0);
        next_cycle();
        bus.HREADYOUTx2 = 1'b1;
        expect_resp("aeserr.c2", 1'b1, 1'b1, 32'h0);
        next_cycle();
        bus.HRESPx2 = 1'b0;
        expect_resp("aeserr.after", 1'b1, 1'b0, 32'h0);

        // asynchronous reset while a memory data phase is stalled
        next_cycle();
        bus.HSELx1 = 1'b1; bus.HTRANS = 2'b10;
        next_cycle();
        idle_bus();
        bus.HRDATAx1 = 32'hDEAD_BEEF; bus.HREADYOUTx1 = 1'b0;
        expect_resp("arst.stalled", 1'b0, 1'b0, 32'hDEAD_BEEF);
        #2;
        HRESET = 1'b1;
        #1;
        check("arst.hready", {31'd0, bus.HREADY}, 32'd1);
        check("arst.hresp",  {31'd0, bus.HRESP},  32'd0);
        check("arst.hrdata", bus.HRDATA, 32'h0);
`ifdef AHB_MUX_ERR_CAPTURE_EN
        check("arst.errvalid", {31'd0, err_valid}, 32'd0);
`endif
        next_cycle();
        HRESET = 1'b0;
        expect_resp("arst.release", 1'b1, 1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_lite_slave_mux.md
Name: ahb_lite_slave_mux

Overview:
- Data-phase response multiplexer for the AHB-Lite bus. Sits directly downstream of the address decoder (memory = slot 1, AES128 = slot 2).
- Registers the decoder's HSEL outputs during the address phase. In the following data phase it routes the owning slave's HRDATA/HREADYOUT/HRESP back to the master as HRDATA/HREADY/HRESP.
- Contains a built-in default slave. Any active transfer to an unmapped address receives the standard two-cycle ERROR response.

Parameters:
- DATA_WIDTH, 32, width of HRDATA buses.
- ADDR_WIDTH, 32, width of HADDR (used only by the optional feature).

Ports:
- HCLK  in  1  bus clock; all state updates on the rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- HSELx1  in  1  memory select from decoder (address phase).
- HSELx2  in  1  AES128 select from decoder (address phase).
- HTRANS  in  2  master transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- HADDR  in  ADDR_WIDTH  master address (address phase).
- HRDATAx1  in  DATA_WIDTH  memory read data.
- HREADYOUTx1  in  1  memory ready.
- HRESPx1  in  1  memory response (0 OKAY, 1 ERROR).
- HRDATAx2  in  DATA_WIDTH  AES128 read data.
- HREADYOUTx2  in  1  AES128 ready.
- HRESPx2  in  1  AES128 response.
- HRDATA  out  DATA_WIDTH  read data to master.
- HREADY  out  1  bus ready to master and to all slaves' HREADY inputs.
- HRESP  out  1  response to master.

Behaviour:
- Data-phase owner register sel_q (2 bits: 01 mem, 10 AES, 00 default). Loaded only on clock edges where HREADY=1: sel_q <= {HSELx2 & ~HSELx1, HSELx1}. HSELx1 wins if both are asserted. Held while HREADY=0.
- Default-slave FSM states:
  - DS_IDLE: drives OKAY/ready when owner.
  - DS_ERR1: HREADY=0, HRESP=1.
  - DS_ERR2: HREADY=1, HRESP=1.
- FSM transitions:
  - DS_IDLE -> DS_ERR1 on an edge with HREADY=1, HSELx1=HSELx2=0, HTRANS[1]=1 (NONSEQ/SEQ).
  - DS_ERR1 -> DS_ERR2 unconditionally.
  - DS_ERR2 -> DS_ERR1 if a new unmapped NONSEQ/SEQ is presented on that edge; otherwise DS_IDLE.
- Unmapped IDLE/BUSY transfers: sel_q=00, FSM stays DS_IDLE, zero-wait OKAY response.
- Output mux (combinational from sel_q and FSM state, no added latency):
  - sel_q=01: HRDATA=HRDATAx1, HREADY=HREADYOUTx1, HRESP=HRESPx1.
  - sel_q=10: same routing from the x2 slave signals.
  - sel_q=00: HRDATA=0. HREADY/HRESP taken from the FSM: DS_IDLE gives 1/0, DS_ERR1 gives 0/1, DS_ERR2 gives 1/1.
- Slave wait states propagate unchanged. Slave two-cycle ERROR responses pass through unchanged.
- Reset (asynchronous assertion, any time including mid-transfer or mid-error):
  - sel_q=00, FSM=DS_IDLE.
  - Outputs therefore read HRDATA=0, HREADY=1, HRESP=0.
  - Any in-flight data phase is abandoned. Slaves are reset by the same HRESET.
- Back-to-back transfers to different slaves switch ownership on the edge ending the previous data phase (HREADY=1). No bubble cycle is inserted.

Optional Feature:
- Macro AHB_MUX_ERR_CAPTURE_EN. When defined, adds two outputs:
  - ERR_ADDR (out, ADDR_WIDTH): loaded with HADDR on each edge where the FSM enters DS_ERR1.
  - ERR_VALID (out, 1): sticky; set on the same edge; cleared only by HRESET.
  - Reset values are 0.
- When undefined, both ports and their registers are absent. Mux behaviour is identical either way.

Test Plan:
- Reset check: assert HRESET mid-sim with HREADYOUTx1=0 and sel_q=01 -> outputs immediately read HREADY=1, HRESP=0, HRDATA=0.
- Memory read: HSELx1=1, HTRANS=10, HRDATAx1=0xDEADBEEF, HREADYOUTx1=0 for 2 cycles then 1 -> HREADY low for exactly 2 data-phase cycles; HRDATA=0xDEADBEEF when HREADY=1.
- Back-to-back: mem NONSEQ then AES NONSEQ, HRDATAx2=0x12345678, HRESPx2=0 -> mem data then AES data on consecutive cycles, no idle cycle between.
- Unmapped access: HSELx1=HSELx2=0, HTRANS=10, HADDR=0x80000000 -> next cycle HREADY=0, HRESP=1; following cycle HREADY=1, HRESP=1. With AHB_MUX_ERR_CAPTURE_EN: ERR_ADDR=0x80000000, ERR_VALID=1.
- Unmapped IDLE: HTRANS=00, no HSEL -> HREADY=1, HRESP=0 every cycle; FSM never leaves DS_IDLE.
- Slave error passthrough: AES drives HRESPx2=1 with HREADYOUTx2 sequence 0 then 1 -> HRESP=1 for both cycles, HREADY=0 then 1.
